// File: rtl/pad_border_if.sv
// FIFO-side handshake bundle for pad_border: input FIFO pop side and output FIFO push side.
// master = padding stage, slave = the FIFOs around it.
interface pad_border_if #(
    parameter int GRAY_DATA_WIDTH = 8
);
    logic                       in_rd_en;
    logic                       in_empty;
    logic [GRAY_DATA_WIDTH-1:0] in_dout;
    logic                       out_wr_en;
    logic                       out_full;
    logic [GRAY_DATA_WIDTH-1:0] out_din;

    modport master (
        output in_rd_en,
        input  in_empty,
        input  in_dout,
        output out_wr_en,
        input  out_full,
        output out_din
    );

    modport slave (
        input  in_rd_en,
        output in_empty,
        output in_dout,
        input  out_wr_en,
        output out_full,
        input  out_din
    );
endinterface

// File: rtl/pad_border.sv
// Wraps a raster grayscale stream in a one-pixel PAD_VALUE border, zero-latency pass-through.
// Define PAD_BORDER_FRAME_DONE_EN to add a registered one-cycle frame_done pulse.
module pad_border #(
    parameter int                         GRAY_DATA_WIDTH = 8,
    parameter int                         IMG_WIDTH       = 720,
    parameter int                         IMG_HEIGHT      = 720,
    parameter logic [GRAY_DATA_WIDTH-1:0] PAD_VALUE       = '0
) (
    input  logic         clock,
    input  logic         reset,
`ifdef PAD_BORDER_FRAME_DONE_EN
    output logic         frame_done,
`endif
    pad_border_if.master fifo_if
);
    localparam int COL_W = $clog2(IMG_WIDTH + 2);
    localparam int ROW_W = $clog2(IMG_HEIGHT + 2);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH + 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT + 1);
    localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);

    localparam logic [0:0] S_WAIT   = 1'b0;
    localparam logic [0:0] S_STREAM = 1'b1;

    logic [0:0]                 r_state;
    logic [COL_W-1:0]           r_col;
    logic [ROW_W-1:0]           r_row;
    logic                       w_col_end;
    logic                       w_border;
    logic                       w_frame_end;
    logic                       w_push;
    logic                       w_pop;
    logic [GRAY_DATA_WIDTH-1:0] w_din;

    assign w_col_end   = (r_col == COL_LAST);
    assign w_border    = (r_row == '0) || (r_row == ROW_LAST) || (r_col == '0) || w_col_end;
    assign w_frame_end = w_col_end && (r_row == ROW_LAST);

    // Outputs are gated by reset so nothing leaks out while a mid-frame reset is held.
    always_comb begin
        w_push = 1'b0;
        w_pop  = 1'b0;
        w_din  = '0;
        if (!reset && (r_state == S_STREAM)) begin
            if (w_border) begin
                w_push = !fifo_if.out_full;
                w_din  = PAD_VALUE;
            end else begin
                w_push = !fifo_if.out_full && !fifo_if.in_empty;
                w_pop  = w_push;
                w_din  = fifo_if.in_dout;
            end
        end
    end

    assign fifo_if.out_wr_en = w_push;
    assign fifo_if.in_rd_en  = w_pop;
    assign fifo_if.out_din   = w_din;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_WAIT;
            r_col   <= '0;
            r_row   <= '0;
        end else begin
            case (r_state)
                S_WAIT: begin
                    if (!fifo_if.in_empty) begin
                        r_state <= S_STREAM;
                    end
                end
                default: begin
                    if (w_push) begin
                        if (w_col_end) begin
                            r_col <= '0;
                            if (w_frame_end) begin
                                r_row   <= '0;
                                r_state <= S_WAIT;
                            end else begin
                                r_row <= r_row + ROW_ONE;
                            end
                        end else begin
                            r_col <= r_col + COL_ONE;
                        end
                    end
                end
            endcase
        end
    end

`ifdef PAD_BORDER_FRAME_DONE_EN
    logic r_frame_done;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_push && w_frame_end;
        end
    end

    assign frame_done = r_frame_done;
`endif
endmodule

// File: tb/tb_pad_border.sv
// Self-checking bench for pad_border (4x3 image): per-cycle reference model plus directed/random scenarios.
module tb_pad_border;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int PW = W + 2;
    localparam int PH = H + 2;
    localparam int N  = PW * PH;
    localparam logic [7:0] PAD = 8'd0;

    logic clock = 1'b0;
    logic reset;
`ifdef PAD_BORDER_FRAME_DONE_EN
    logic frame_done;
`endif

    pad_border_if #(.GRAY_DATA_WIDTH(8)) bus ();

    pad_border #(
        .GRAY_DATA_WIDTH(8),
        .IMG_WIDTH(W),
        .IMG_HEIGHT(H),
        .PAD_VALUE(PAD)
    ) dut (
        .clock(clock),
        .reset(reset),
`ifdef PAD_BORDER_FRAME_DONE_EN
        .frame_done(frame_done),
`endif
        .fifo_if(bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    logic [7:0] q[$];
    logic [7:0] wlog[$];
    int wcyc[$];
    int n_wr = 0;
    int n_rd = 0;
    int cyc = 0;
    bit full_req = 1'b0;
    bit starve = 1'b0;
    bit rst_req = 1'b1;
    bit rnd_mode = 1'b0;
    int rnd_left = 0;
    // Reference model: frame position as a flat index, plus an "in a frame" flag.
    bit m_active = 1'b0;
    int m_pos = 0;
    bit m_fd = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic cycle();
        bit e_wr, e_rd, brd, a_wr, a_rd, emp;
        logic [7:0] a_din;
        int r, c;
        if (rnd_mode) begin
            full_req = ($urandom_range(0, 3) == 0);
            starve   = ($urandom_range(0, 3) == 0);
            if (rnd_left > 0 && $urandom_range(0, 1) == 1) begin
                q.push_back(8'($urandom_range(0, 255)));
                rnd_left--;
            end
        end
        emp = starve || (q.size() == 0);
        bus.in_empty = emp;
        bus.in_dout  = emp ? 8'h00 : q[0];
        bus.out_full = full_req;
        reset        = rst_req;
        @(negedge clock);
        r   = m_pos / PW;
        c   = m_pos % PW;
        brd = (r == 0) || (r == PH - 1) || (c == 0) || (c == PW - 1);
        e_wr = 1'b0;
        e_rd = 1'b0;
        if (!rst_req && m_active) begin
            if (brd) begin
                e_wr = !full_req;
            end else begin
                e_wr = !full_req && !emp;
                e_rd = e_wr;
            end
        end
        chk("out_wr_en", 32'(bus.out_wr_en), 32'(e_wr));
        chk("in_rd_en", 32'(bus.in_rd_en), 32'(e_rd));
        if (rst_req || !m_active) chk("out_din_idle", 32'(bus.out_din), 32'd0);
        else if (brd) chk("out_din_pad", 32'(bus.out_din), 32'(PAD));
        else if (e_wr) chk("out_din_pass", 32'(bus.out_din), 32'(q[0]));
`ifdef PAD_BORDER_FRAME_DONE_EN
        chk("frame_done", 32'(frame_done), 32'(m_fd));
`endif
        a_wr  = (bus.out_wr_en === 1'b1);
        a_rd  = (bus.in_rd_en === 1'b1);
        a_din = bus.out_din;
        @(posedge clock);
        #1;
        if (a_rd) begin
            n_rd++;
            if (!emp) q.delete(0);
        end
        if (a_wr) begin
            n_wr++;
            wlog.push_back(a_din);
            wcyc.push_back(cyc);
        end
        m_fd = !rst_req && e_wr && (m_pos == N - 1);
        if (rst_req) begin
            m_active = 1'b0;
            m_pos    = 0;
        end else if (!m_active) begin
            m_active = !emp;
        end else if (e_wr) begin
            m_pos++;
            if (m_pos == N) begin
                m_pos    = 0;
                m_active = 1'b0;
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic run_writes(input int target, input int budget, input string name);
        int k;
        k = 0;
        while (n_wr < target && k < budget) begin
            cycle();
            k++;
        end
        chk(name, 32'(n_wr), 32'(target));
    endtask

    task automatic load(input int first, input int count);
        for (int i = 0; i < count; i++) q.push_back(8'(first + i));
    endtask

    initial begin
        int base, base2, b0, k, r0, nz;
        bus.in_empty = 1'b1;
        bus.in_dout  = 8'h00;
        bus.out_full = 1'b0;
        reset        = 1'b1;

        // Reset state
        rst_req = 1'b1;
        idle(3);
        chk("reset_no_writes", 32'(n_wr), 32'd0);
        chk("reset_no_reads", 32'(n_rd), 32'd0);

        // Basic frame
        load(1, 12);
        rst_req = 1'b0;
        base = n_wr;
        b0   = n_rd;
        run_writes(base + 30, 80, "basic_timeout");
        chk("basic_consecutive", 32'(wcyc[base + 29] - wcyc[base]), 32'd29);
        chk("basic_pops", 32'(n_rd - b0), 32'd12);
        nz = 0;
        for (int i = 0; i < PW; i++) begin
            nz += (wlog[base + i] != 8'd0) ? 1 : 0;
            nz += (wlog[base + 24 + i] != 8'd0) ? 1 : 0;
        end
        chk("basic_rows0_4_pad", 32'(nz), 32'd0);
        for (int i = 0; i < PW; i++) begin
            chk("basic_row1", 32'(wlog[base + 6 + i]), (i == 0 || i == 5) ? 32'd0 : 32'(i));
            chk("basic_row3", 32'(wlog[base + 18 + i]), (i == 0 || i == 5) ? 32'd0 : 32'(8 + i));
        end
        k = n_wr;
        idle(5);
        chk("basic_wait_after_frame", 32'(n_wr - k), 32'd0);

        // Input starvation
        base = n_wr;
        b0   = n_rd;
        load(1, 5);
        run_writes(base + 14, 60, "starve_reach_stall");
        chk("starve_last_pad", 32'(wlog[base + 12]), 32'd0);
        chk("starve_last_pixel", 32'(wlog[base + 13]), 32'd5);
        k  = n_wr;
        r0 = n_rd;
        idle(10);
        chk("starve_no_write", 32'(n_wr - k), 32'd0);
        chk("starve_no_read", 32'(n_rd - r0), 32'd0);
        load(6, 7);
        run_writes(base + 30, 60, "starve_complete");
        chk("starve_pops", 32'(n_rd - b0), 32'd12);

        // Output backpressure at row 1, col 3
        base = n_wr;
        b0   = n_rd;
        load(1, 12);
        run_writes(base + 9, 40, "bp_reach");
        full_req = 1'b1;
        k  = n_wr;
        r0 = n_rd;
        idle(7);
        chk("bp_no_write", 32'(n_wr - k), 32'd0);
        chk("bp_no_read", 32'(n_rd - r0), 32'd0);
        chk("bp_held_pixel", 32'(q[0]), 32'd3);
        full_req = 1'b0;
        run_writes(base + 30, 60, "bp_complete");
        chk("bp_seq0", 32'(wlog[base + 9]), 32'd3);
        chk("bp_seq1", 32'(wlog[base + 10]), 32'd4);
        chk("bp_seq2", 32'(wlog[base + 11]), 32'd0);
        chk("bp_pops", 32'(n_rd - b0), 32'd12);

        // Back-to-back frames
        base = n_wr;
        load(1, 24);
        run_writes(base + 60, 150, "b2b_timeout");
        nz = 0;
        for (int i = 0; i < 60; i++) nz += (wlog[base + i] == 8'd0) ? 1 : 0;
        chk("b2b_border_zeros", 32'(nz), 32'd36);
        for (int r = 1; r <= H; r++) begin
            for (int c = 1; c <= W; c++) begin
                chk("b2b_frame2_interior", 32'(wlog[base + 30 + r * PW + c]), 32'(12 + (r - 1) * W + c));
            end
        end
        chk("b2b_gap", 32'(wcyc[base + 30] - wcyc[base + 29]), 32'd2);

        // Reset mid-frame
        base = n_wr;
        load(1, 12);
        run_writes(base + 15, 40, "rst_reach");
        rst_req = 1'b1;
        cycle();
        rst_req = 1'b0;
        q.delete();
        load(101, 12);
        k  = n_wr;
        r0 = n_rd;
        cycle();
        chk("rst_next_no_write", 32'(n_wr - k), 32'd0);
        chk("rst_next_no_read", 32'(n_rd - r0), 32'd0);
        base2 = n_wr;
        b0    = n_rd;
        run_writes(base2 + 30, 80, "rst_refill_frame");
        chk("rst_first_pixel", 32'(wlog[base2 + 7]), 32'd101);
        chk("rst_last_pixel", 32'(wlog[base2 + 22]), 32'd112);
        chk("rst_pops", 32'(n_rd - b0), 32'd12);

        // Randomised traffic: three frames with random stalls on both sides
        rnd_mode = 1'b1;
        rnd_left = 3 * W * H;
        base = n_wr;
        b0   = n_rd;
        run_writes(base + 3 * N, 3000, "random_frames");
        rnd_mode = 1'b0;
        full_req = 1'b0;
        starve   = 1'b0;
        k = n_wr;
        idle(5);
        chk("random_no_extra_writes", 32'(n_wr - k), 32'd0);
        chk("random_pops", 32'(n_rd - b0), 32'(3 * W * H));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
